// File: rtl/folded_dense_layer_pkg.sv
// +----------------------------------------------------------------------------+
// | folded_dense_layer_pkg : shared types, sigmoid PLAN constants, narrowing.   |
// | Macro FOLDED_DENSE_SATURATE_EN selects clamp (defined) or wrap narrowing.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package folded_dense_layer_pkg;

  typedef enum logic [1:0] {RELU, SIGMOID, LINEAR} activation_t;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_FINAL, ST_DONE} state_t;

  typedef struct packed {
    logic clear;
    logic enable;
  } lane_ctrl_t;

  // PLAN breakpoints/offsets as num / 2^sh in real units, slopes as right shifts.
  localparam int PLAN_SAT_NUM     = 5;
  localparam int PLAN_SAT_SH      = 0;
  localparam int PLAN_HI_THR_NUM  = 19;
  localparam int PLAN_HI_THR_SH   = 3;
  localparam int PLAN_HI_OFS_NUM  = 27;
  localparam int PLAN_HI_OFS_SH   = 5;
  localparam int PLAN_MID_OFS_NUM = 5;
  localparam int PLAN_MID_OFS_SH  = 3;
  localparam int PLAN_LO_OFS_NUM  = 1;
  localparam int PLAN_LO_OFS_SH   = 1;
  localparam int PLAN_HI_SLOPE_SH  = 5;
  localparam int PLAN_MID_SLOPE_SH = 3;
  localparam int PLAN_LO_SLOPE_SH  = 2;

  function automatic longint plan_const(input int num, input int sh, input int frac);
    return (longint'(num) <<< frac) >>> sh;
  endfunction

  // Result is the narrowed value sign-extended back to 128 bits.
  function automatic logic signed [127:0] narrow_fx(input logic signed [127:0] v,
                                                     input int unsigned dw);
`ifdef FOLDED_DENSE_SATURATE_EN
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    return (v <<< (128 - dw)) >>> (128 - dw);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/folded_dense_layer_mac_lane.sv
// +----------------------------------------------------------------------------+
// | folded_dense_layer_mac_lane : accumulator, rescale, bias, narrow, activate. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module folded_dense_layer_mac_lane
  import folded_dense_layer_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          FRAC_WIDTH = 16,
  parameter int          ACC_WIDTH  = 69,
  parameter activation_t ACTIVATION = RELU
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  lane_ctrl_t                   ctrl_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  input  logic signed [DATA_WIDTH-1:0] bias_i,
  output logic signed [DATA_WIDTH-1:0] result_o
);

  localparam int SUM_WIDTH = ACC_WIDTH + 1;

  localparam logic signed [DATA_WIDTH:0] c_one     = (DATA_WIDTH+1)'(plan_const(1, 0, FRAC_WIDTH));
  localparam logic signed [DATA_WIDTH:0] c_sat_thr = (DATA_WIDTH+1)'(plan_const(PLAN_SAT_NUM, PLAN_SAT_SH, FRAC_WIDTH));
  localparam logic signed [DATA_WIDTH:0] c_hi_thr  = (DATA_WIDTH+1)'(plan_const(PLAN_HI_THR_NUM, PLAN_HI_THR_SH, FRAC_WIDTH));
  localparam logic signed [DATA_WIDTH:0] c_hi_ofs  = (DATA_WIDTH+1)'(plan_const(PLAN_HI_OFS_NUM, PLAN_HI_OFS_SH, FRAC_WIDTH));
  localparam logic signed [DATA_WIDTH:0] c_mid_ofs = (DATA_WIDTH+1)'(plan_const(PLAN_MID_OFS_NUM, PLAN_MID_OFS_SH, FRAC_WIDTH));
  localparam logic signed [DATA_WIDTH:0] c_lo_ofs  = (DATA_WIDTH+1)'(plan_const(PLAN_LO_OFS_NUM, PLAN_LO_OFS_SH, FRAC_WIDTH));

  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_shift;
  logic signed [SUM_WIDTH-1:0]    w_sum;
  logic signed [DATA_WIDTH-1:0]   w_nar;
  logic signed [DATA_WIDTH:0]     w_ext, w_y, w_pos;

  assign w_prod = x_i * w_i;

  always_comb begin
    acc_d = acc_q;
    if (ctrl_i.clear)       acc_d = '0;
    else if (ctrl_i.enable) acc_d = acc_q + ACC_WIDTH'(w_prod);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  // Arithmetic shift drops fraction toward -inf before the bias is added.
  assign w_shift = acc_q >>> FRAC_WIDTH;
  assign w_sum   = SUM_WIDTH'(w_shift) + SUM_WIDTH'(bias_i);
  assign w_nar   = DATA_WIDTH'(narrow_fx({{(128-SUM_WIDTH){w_sum[SUM_WIDTH-1]}}, w_sum}, DATA_WIDTH));

  assign w_ext = {w_nar[DATA_WIDTH-1], w_nar};
  assign w_y   = w_nar[DATA_WIDTH-1] ? -w_ext : w_ext;

  always_comb begin
    w_pos = (w_y >>> PLAN_LO_SLOPE_SH) + c_lo_ofs;
    if (w_y >= c_sat_thr)     w_pos = c_one;
    else if (w_y >= c_hi_thr) w_pos = (w_y >>> PLAN_HI_SLOPE_SH) + c_hi_ofs;
    else if (w_y >= c_one)    w_pos = (w_y >>> PLAN_MID_SLOPE_SH) + c_mid_ofs;
  end

  always_comb begin
    result_o = w_nar;
    case (ACTIVATION)
      RELU:    result_o = w_nar[DATA_WIDTH-1] ? '0 : w_nar;
      SIGMOID: result_o = DATA_WIDTH'(w_nar[DATA_WIDTH-1] ? (c_one - w_pos) : w_pos);
      default: result_o = w_nar;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/folded_dense_layer.sv
// +----------------------------------------------------------------------------+
// | folded_dense_layer : NUM_NEURONS outputs folded onto NUM_MACS MAC lanes.    |
// | Narrowing clamps when FOLDED_DENSE_SATURATE_EN is defined, else wraps.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module folded_dense_layer
  import folded_dense_layer_pkg::*;
#(
  parameter int          INTG_WIDTH  = 16,
  parameter int          FRAC_WIDTH  = 16,
  parameter int          NUM_INPUTS  = 16,
  parameter int          NUM_NEURONS = 16,
  parameter int          NUM_MACS    = 4,
  parameter activation_t ACTIVATION  = RELU,
  localparam int         DATA_WIDTH  = INTG_WIDTH + FRAC_WIDTH,
  // ROM images: weight (n, k) at slot n*NUM_INPUTS+k, bias n at slot n.
  parameter logic [NUM_NEURONS*NUM_INPUTS*DATA_WIDTH-1:0] WEIGHTS = '0,
  parameter logic [NUM_NEURONS*DATA_WIDTH-1:0]            BIASES  = '0
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    inputs_valid,
  output logic                                    inputs_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]   inputs,
  output logic                                    outputs_valid,
  input  logic                                    outputs_ready,
  output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]  outputs
);

  localparam int GROUPS    = NUM_NEURONS / NUM_MACS;
  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(NUM_INPUTS + 1);
  localparam int K_W       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int G_W       = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (NUM_NEURONS % NUM_MACS != 0) begin : g_bad_fold
    $error("folded_dense_layer: NUM_MACS must divide NUM_NEURONS");
  end

  state_t                                  state_q, state_d;
  logic [K_W-1:0]                          k_q, k_d;
  logic [G_W-1:0]                          g_q, g_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]   x_q;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]  out_q;
  logic                                    w_load, w_write;
  lane_ctrl_t                              w_ctrl;
  logic signed [DATA_WIDTH-1:0]            w_lane_res [NUM_MACS];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    w_load  = 1'b0;
    w_write = 1'b0;
    w_ctrl  = '0;
    case (state_q)
      ST_IDLE: begin
        if (inputs_valid) begin
          w_load  = 1'b1;
          g_d     = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        w_ctrl.enable = 1'b1;
        if (k_q == K_W'(NUM_INPUTS - 1)) state_d = ST_FINAL;
        else                              k_d     = k_q + 1'b1;
      end
      ST_FINAL: begin
        w_write      = 1'b1;
        w_ctrl.clear = 1'b1;
        if (g_q == G_W'(GROUPS - 1)) begin
          state_d = ST_DONE;
        end else begin
          g_d     = g_q + 1'b1;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        if (outputs_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      g_q     <= '0;
      x_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
      if (w_load) x_q <= inputs;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (w_write && (n / NUM_MACS) == int'(g_q)) out_q[n] <= w_lane_res[n % NUM_MACS];
      end
    end
  end

  for (genvar j = 0; j < NUM_MACS; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_w, w_b;

    always_comb begin
      w_w = WEIGHTS[((int'(g_q)*NUM_MACS + j)*NUM_INPUTS + int'(k_q))*DATA_WIDTH +: DATA_WIDTH];
      w_b = BIASES[(int'(g_q)*NUM_MACS + j)*DATA_WIDTH +: DATA_WIDTH];
    end

    folded_dense_layer_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .ACTIVATION (ACTIVATION)
    ) u_lane (
      .clock_i  (clock),
      .reset_i  (reset),
      .ctrl_i   (w_ctrl),
      .x_i      (x_q[k_q]),
      .w_i      (w_w),
      .bias_i   (w_b),
      .result_o (w_lane_res[j])
    );
  end

  assign inputs_ready  = (state_q == ST_IDLE);
  assign outputs_valid = (state_q == ST_DONE);
  assign outputs       = out_q;

endmodule

`default_nettype wire
